flow_pattern_ctrl: RTL and testbench
====================================

Name: flow_pattern_ctrl

Overview:
Sequencer for the board's 8-lane LED/pin output bank. It owns the output pattern register, the pattern-step prescaler and the two push-button controls. It debounces the board keys and steps one of five selectable patterns on each prescaler tick. A heartbeat LED toggles with every step. It sits directly under the board top level: raw key pins come in, and the lanes go out to the header pins.

Parameters:
TICK_DIV, 16777216, sys_clk cycles per pattern step (2^24); legal range is 2 or more.
DEB_CYCLES, 1000000, consecutive stable synchronized cycles needed to accept a key level change.

Ports:
sys_clk  in  1  system clock; single clock domain.
sys_rst  in  1  synchronous, active-high reset.
key_mode_n  in  1  raw mode key, active-low, asynchronous to sys_clk.
key_pause_n  in  1  raw pause key, active-low, asynchronous to sys_clk.
lanes  out  8  pattern register, driven to output pins.
led  out  1  heartbeat; toggles on every executed step.
mode  out  3  current mode: 0 ROT_R, 1 ROT_L, 2 BOUNCE, 3 BLINK, 4 COUNT.
paused  out  1  1 while stepping is frozen.
tick  out  1  one-cycle step strobe, for debug.

Behaviour:
- Reset values (sys_rst sampled high at a clock edge):
  - lanes=8'h01, mode=0, paused=0, led=0, tick=0.
  - Prescaler count=0, bounce direction=UP (toward MSB).
  - Debounced keys=released (1), debounce counters=0, synchronizers=1.
- Reset asserted mid-operation aborts everything on that edge; there is no partial step.
- Key path, per key:
  - 2-FF synchronizer, then a debounce counter.
  - If the synchronized level differs from the debounced level, the counter increments; any sample equal to the debounced level clears it.
  - When the counter reaches DEB_CYCLES, the debounced level updates and the counter clears.
  - A press pulse is one cycle, on the debounced 1->0 transition only; release generates nothing.
- Prescaler:
  - Counts 0..TICK_DIV-1. tick=1 for the one cycle when count==TICK_DIV-1, and count wraps to 0 on that cycle.
  - The first tick comes TICK_DIV cycles after reset deasserts.
  - While paused, count holds and tick=0.
- Mode press:
  - mode advances 0->1->2->3->4->0.
  - Prescaler count clears and bounce direction sets to UP.
  - lanes loads the seed for the new mode: ROT_R/ROT_L/BOUNCE seed 8'h01, BLINK/COUNT seed 8'h00.
  - A mode press is accepted while paused; the seed loads and paused stays set.
- Pause press toggles paused. Mode and pause presses in the same cycle both take effect.
- Step, on tick (not paused, no mode press this cycle), with led toggling:
  - ROT_R: lanes <= {lanes[0], lanes[7:1]}.
  - ROT_L: lanes <= {lanes[6:0], lanes[7]}.
  - BOUNCE: UP gives lanes<<1, and direction flips to DOWN when the result is 8'h80. DOWN gives lanes>>1, and direction flips to UP when the result is 8'h01. Sequence: 01,02,...,80,40,...,01,02. In BOUNCE, lanes is always one-hot.
  - BLINK: lanes <= ~lanes.
  - COUNT: lanes <= lanes+1, modulo 256 (FF->00, no flag).
- A tick coinciding with a mode press is discarded: seed loads, led does not toggle, count clears.
- Unreachable mode codes 5-7 decode as ROT_R and advance to 0 on the next press.
- All outputs are registered; there are no combinational paths from keys to outputs.

Decomposition:
- Package flow_pkg holds:
  - mode enum MODE_ROT_R..MODE_COUNT and MODE_LAST=4;
  - seed constants SEED_ONEHOT=8'h01, SEED_ZERO=8'h00;
  - direction enum UP/DOWN.
- One sub-module, key_debounce (parameter DEB_CYCLES; ports sys_clk, sys_rst, key_n, level, press), instantiated twice.
- Prescaler and pattern FSM stay in flow_pattern_ctrl.

Test Plan (bench uses TICK_DIV=4, DEB_CYCLES=3):
- Reset release, no keys -> ticks at cycles 4, 8, 12 after release; lanes 01->80->40->20; led toggles 0->1->0->1.
- Mode key held low for 10 cycles -> exactly one press; mode=1, lanes=01, count cleared. Next ticks give lanes 02, 04; key release gives no second press.
- Mode key bouncing (low 2, high 1, low 2, high 1 cycles), then held low -> press only after 3 consecutive low synchronized samples; mode increments exactly once.
- BOUNCE mode, 16 ticks -> lanes 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04; never non-one-hot.
- COUNT mode with lanes forced to FF via 255 ticks -> next tick gives 00. Pause press -> lanes, led and count frozen for 20 cycles. Second pause press -> stepping resumes from the held count.
- Mode press on the same cycle as tick in BLINK -> mode=4, lanes=00, led unchanged. Then sys_rst asserted mid-count -> lanes=01, mode=0, paused=0 on the next edge.

Source files
------------

// File: rtl/flow_pkg.sv
// Shared types and constants for the LED lane pattern sequencer.
// Mode codes, pattern seeds and bounce direction live here so the top and the bench agree.
package flow_pkg;

   typedef enum logic [2:0] {
      MODE_ROT_R  = 3'd0,
      MODE_ROT_L  = 3'd1,
      MODE_BOUNCE = 3'd2,
      MODE_BLINK  = 3'd3,
      MODE_COUNT  = 3'd4
   } mode_t;

   localparam mode_t MODE_LAST = MODE_COUNT;

   localparam logic [7:0] SEED_ONEHOT = 8'h01;
   localparam logic [7:0] SEED_ZERO   = 8'h00;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   // Codes past MODE_LAST (never reached normally) fold back to ROT_R.
   function automatic logic [2:0] next_mode(input logic [2:0] m);
      logic [2:0] r;
      if (m >= MODE_LAST) begin
         r = MODE_ROT_R;
      end else begin
         r = m + 3'd1;
      end
      return r;
   endfunction

   function automatic logic [7:0] seed_for(input logic [2:0] m);
      logic [7:0] s;
      if (m == MODE_BLINK || m == MODE_COUNT) begin
         s = SEED_ZERO;
      end else begin
         s = SEED_ONEHOT;
      end
      return s;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low push button.
// press is a single-cycle pulse on the accepted 1->0 change of the debounced level.
module key_debounce
   import flow_pkg::*;
#(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] count;

   // The level only moves after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         count <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != level) begin
            if (count == CNT_LAST) begin
               level <= sync2;
               count <= '0;
               press <= ~sync2;
            end else begin
               count <= count + CW'(1);
            end
         end else begin
            count <= '0;
         end
      end
   end

endmodule

// File: rtl/flow_pattern_ctrl.sv
// Pattern sequencer for the 8-lane output bank: key handling, step prescaler and pattern register.
// Every output is a flop; keys reach the outputs only through the debouncers.
module flow_pattern_ctrl
   import flow_pkg::*;
#(
   parameter int TICK_DIV   = 16777216,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_mode_n,
   input  logic       key_pause_n,
   output logic [7:0] lanes,
   output logic       led,
   output logic [2:0] mode,
   output logic       paused,
   output logic       tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

   logic          mode_level;
   logic          mode_press;
   logic          pause_level;
   logic          pause_press;
   logic          mode_hit;
   logic          pause_hit;
   logic [2:0]    mode_nxt;
   logic [PW-1:0] count;
   dir_t          dir;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_key (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_n   (key_mode_n),
      .level   (mode_level),
      .press   (mode_press)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause_key (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_n   (key_pause_n),
      .level   (pause_level),
      .press   (pause_press)
   );

   assign mode_hit  = mode_press & ~mode_level;
   assign pause_hit = pause_press & ~pause_level;
   assign mode_nxt  = next_mode(mode);

   // A mode press wins over a coinciding tick: the seed loads and that step is dropped.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         lanes  <= SEED_ONEHOT;
         mode   <= MODE_ROT_R;
         paused <= 1'b0;
         led    <= 1'b0;
         tick   <= 1'b0;
         count  <= '0;
         dir    <= UP;
      end else begin
         tick <= 1'b0;
         if (pause_hit) begin
            paused <= ~paused;
         end
         if (mode_hit) begin
            mode  <= mode_nxt;
            lanes <= seed_for(mode_nxt);
            count <= '0;
            dir   <= UP;
         end else if (!paused) begin
            if (count == DIV_LAST) begin
               count <= '0;
               tick  <= 1'b1;
               led   <= ~led;
               case (mode)
                  MODE_ROT_L: begin
                     lanes <= {lanes[6:0], lanes[7]};
                  end
                  MODE_BOUNCE: begin
                     if (dir == UP) begin
                        lanes <= {lanes[6:0], 1'b0};
                        if ({lanes[6:0], 1'b0} == 8'h80) begin
                           dir <= DOWN;
                        end
                     end else begin
                        lanes <= {1'b0, lanes[7:1]};
                        if ({1'b0, lanes[7:1]} == 8'h01) begin
                           dir <= UP;
                        end
                     end
                  end
                  MODE_BLINK: begin
                     lanes <= ~lanes;
                  end
                  MODE_COUNT: begin
                     lanes <= lanes + 8'd1;
                  end
                  default: begin
                     lanes <= {lanes[0], lanes[7:1]};
                  end
               endcase
            end else begin
               count <= count + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_flow_pattern_ctrl.sv
// Bench for flow_pattern_ctrl: directed vector table, corner-case sequences and a random run
// checked every cycle against a behavioural model of the key, prescaler and pattern rules.
module tb_flow_pattern_ctrl;

   localparam int TICK_DIV = 4;
   localparam int DEB      = 3;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       key_mode_n;
   logic       key_pause_n;
   logic [7:0] lanes;
   logic       led;
   logic [2:0] mode;
   logic       paused;
   logic       tick;

   flow_pattern_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_mode_n  (key_mode_n),
      .key_pause_n (key_pause_n),
      .lanes       (lanes),
      .led         (led),
      .mode        (mode),
      .paused      (paused),
      .tick        (tick)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic rst;
      logic km;
      logic kp;
      int   cycles;
      int   lanes;
      int   mode;
      int   paused;
      int   led;
      int   tick;
   } vec_t;

   vec_t vecs[$];

   bit m_valid = 0;
   int m_lanes, m_mode, m_paused, m_led, m_tick, m_phase, m_up;
   int m_sy1[2], m_sy2[2], m_lvl[2], m_run[2], m_prs[2];

   task automatic check_output(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic km, input logic kp);
      int pins[2];
      int pm, pp;
      pins[0] = int'(km);
      pins[1] = int'(kp);
      if (rst) begin
         m_valid = 1;
         m_lanes = 1; m_mode = 0; m_paused = 0; m_led = 0; m_tick = 0;
         m_phase = 0; m_up = 1;
         for (int k = 0; k < 2; k++) begin
            m_sy1[k] = 1; m_sy2[k] = 1; m_lvl[k] = 1; m_run[k] = 0; m_prs[k] = 0;
         end
      end else begin
         pm = m_prs[0];
         pp = m_prs[1];
         m_tick = 0;
         if (pm != 0) begin
            m_mode  = (m_mode >= 4) ? 0 : m_mode + 1;
            m_lanes = (m_mode <= 2) ? 1 : 0;
            m_phase = 0;
            m_up    = 1;
         end else if (m_paused == 0) begin
            if (m_phase == TICK_DIV - 1) begin
               m_phase = 0;
               m_tick  = 1;
               m_led   = 1 - m_led;
               case (m_mode)
                  1: m_lanes = (m_lanes * 2) % 256 + m_lanes / 128;
                  2: begin
                     if (m_up != 0) begin
                        m_lanes = m_lanes * 2;
                        if (m_lanes == 128) m_up = 0;
                     end else begin
                        m_lanes = m_lanes / 2;
                        if (m_lanes == 1) m_up = 1;
                     end
                  end
                  3: m_lanes = 255 - m_lanes;
                  4: m_lanes = (m_lanes + 1) % 256;
                  default: m_lanes = m_lanes / 2 + (m_lanes % 2) * 128;
               endcase
            end else begin
               m_phase = m_phase + 1;
            end
         end
         if (pp != 0) m_paused = 1 - m_paused;
         for (int k = 0; k < 2; k++) begin
            m_prs[k] = 0;
            if (m_sy2[k] != m_lvl[k]) begin
               m_run[k] = m_run[k] + 1;
               if (m_run[k] == DEB) begin
                  m_lvl[k] = m_sy2[k];
                  m_run[k] = 0;
                  m_prs[k] = (m_sy2[k] == 0) ? 1 : 0;
               end
            end else begin
               m_run[k] = 0;
            end
            m_sy2[k] = m_sy1[k];
            m_sy1[k] = pins[k];
         end
      end
   endtask

   task automatic model_check();
      if (m_valid) begin
         check_output("model lanes", lanes, m_lanes);
         check_output("model mode", mode, m_mode);
         check_output("model paused", paused, m_paused);
         check_output("model led", led, m_led);
         check_output("model tick", tick, m_tick);
      end
   endtask

   task automatic apply_stimulus(input logic rst, input logic km, input logic kp);
      sys_rst     = rst;
      key_mode_n  = km;
      key_pause_n = kp;
      model_step(rst, km, kp);
      @(posedge sys_clk);
      @(negedge sys_clk);
      model_check();
   endtask

   task automatic add_vec(input logic rst, input logic km, input logic kp, input int cycles,
                          input int l, input int md, input int p, input int ld, input int t);
      vec_t v;
      v.rst = rst; v.km = km; v.kp = kp; v.cycles = cycles;
      v.lanes = l; v.mode = md; v.paused = p; v.led = ld; v.tick = t;
      vecs.push_back(v);
   endtask

   task automatic press_key(input bit which_pause);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, which_pause, !which_pause);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 1'b1);
   endtask

   task automatic wait_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
   endtask

   initial begin
      int bseq[16];
      int guard;
      int exp_led, save_l, save_led;
      logic km_r, kp_r, rst_r;

      bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

      add_vec(1, 1, 1, 2,  8'h01, 0, 0, 0, 0);
      add_vec(0, 1, 1, 3,  8'h01, 0, 0, 0, 0);
      add_vec(0, 1, 1, 1,  8'h80, 0, 0, 1, 1);
      add_vec(0, 1, 1, 4,  8'h40, 0, 0, 0, 1);
      add_vec(0, 1, 1, 4,  8'h20, 0, 0, 1, 1);
      add_vec(0, 0, 1, 10, 8'h02, 1, 0, 1, 1);
      add_vec(0, 1, 1, 4,  8'h04, 1, 0, 0, 1);
      add_vec(0, 1, 1, 4,  8'h08, 1, 0, 1, 1);
      add_vec(0, 0, 1, 2,  8'h08, 1, 0, 1, 0);
      add_vec(0, 1, 1, 1,  8'h08, 1, 0, 1, 0);
      add_vec(0, 0, 1, 2,  8'h10, 1, 0, 0, 0);
      add_vec(0, 1, 1, 1,  8'h10, 1, 0, 0, 0);
      add_vec(0, 0, 1, 5,  8'h20, 1, 0, 1, 0);
      add_vec(0, 0, 1, 1,  8'h01, 2, 0, 1, 0);
      for (int i = 0; i < 16; i++) add_vec(0, 1, 1, 4, bseq[i], 2, 0, i % 2, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         for (int c = 0; c < vecs[i].cycles; c++) apply_stimulus(vecs[i].rst, vecs[i].km, vecs[i].kp);
         check_output($sformatf("vec%0d lanes", i), lanes, vecs[i].lanes);
         check_output($sformatf("vec%0d mode", i), mode, vecs[i].mode);
         check_output($sformatf("vec%0d paused", i), paused, vecs[i].paused);
         check_output($sformatf("vec%0d led", i), led, vecs[i].led);
         check_output($sformatf("vec%0d tick", i), tick, vecs[i].tick);
      end

      // BOUNCE -> BLINK, then a mode press timed to land on the prescaler wrap.
      press_key(1'b0);
      check_output("blink mode", mode, 3);
      guard = 0;
      while (m_phase != 2 && guard < 16) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         guard++;
      end
      if (guard >= 16) wait_fail("align phase");
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
      exp_led = m_led;
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output("coincide mode", mode, 4);
      check_output("coincide lanes", lanes, 8'h00);
      check_output("coincide tick", tick, 0);
      check_output("coincide led", led, exp_led);
      for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 1'b1);

      // COUNT up to FF, then the modulo wrap.
      guard = 0;
      while (m_lanes != 255 && guard < 1200) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         guard++;
      end
      if (guard >= 1200) wait_fail("count to ff");
      check_output("count ff", lanes, 8'hFF);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b1);
      check_output("count wrap lanes", lanes, 8'h00);
      check_output("count wrap tick", tick, 1);

      // Pause freezes lanes, led and the prescaler; a second press resumes.
      for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("pause on", paused, 1);
      save_l   = m_lanes;
      save_led = m_led;
      for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1);
         check_output("frozen lanes", lanes, save_l);
         check_output("frozen led", led, save_led);
         check_output("frozen tick", tick, 0);
      end
      for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("pause off", paused, 0);
      for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 1'b1);

      // Reset in the middle of counting.
      for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b1, 1'b1);
      check_output("midreset lanes", lanes, 8'h01);
      check_output("midreset mode", mode, 0);
      check_output("midreset paused", paused, 0);
      check_output("midreset led", led, 0);
      check_output("midreset tick", tick, 0);

      km_r = 1'b1;
      kp_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) km_r = ~km_r;
         if ($urandom_range(0, 5) == 0) kp_r = ~kp_r;
         rst_r = ($urandom_range(0, 499) == 0);
         apply_stimulus(rst_r, km_r, kp_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
